// File: rtl/titan_mem_arbiter_if.sv
// Bus bundle for titan_mem_arbiter: I-port, D-port and the shared memory bus.
// The arbiter takes the slave view; requesters and memory take the master view.
interface titan_mem_arbiter_if;
    logic [31:0] iport_addr;
    logic        iport_req;
    logic        iport_kill;
    logic [31:0] iport_rdata;
    logic        iport_ready;
    logic        iport_error;

    logic [31:0] dport_addr;
    logic [31:0] dport_wdata;
    logic [3:0]  dport_wr;
    logic        dport_req;
    logic [31:0] dport_rdata;
    logic        dport_ready;
    logic        dport_error;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_error;

    modport slave (
        input  iport_addr, iport_req, iport_kill,
        output iport_rdata, iport_ready, iport_error,
        input  dport_addr, dport_wdata, dport_wr, dport_req,
        output dport_rdata, dport_ready, dport_error,
        output mem_addr, mem_wdata, mem_wr, mem_valid,
        input  mem_rdata, mem_ready, mem_error
    );

    modport master (
        output iport_addr, iport_req, iport_kill,
        input  iport_rdata, iport_ready, iport_error,
        output dport_addr, dport_wdata, dport_wr, dport_req,
        input  dport_rdata, dport_ready, dport_error,
        input  mem_addr, mem_wdata, mem_wr, mem_valid,
        output mem_rdata, mem_ready, mem_error
    );
endinterface

// File: rtl/titan_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one registered 32-bit memory bus, D priority with I starvation guard.
// Optional bus-wait timeout is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module titan_mem_arbiter #(
    parameter int unsigned STARVE_MAX     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    titan_mem_arbiter_if.slave   bus
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    if (STARVE_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("titan_mem_arbiter: STARVE_MAX and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          kill_pend_q, kill_pend_d;
    logic          gnt_d_q, gnt_d_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wr_q, mem_wr_d;
    logic          mem_valid_q, mem_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        kill_pend_d  = kill_pend_q;
        gnt_d_d      = gnt_d_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_d     = mem_wr_q;
        mem_valid_d  = mem_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_error_d  = rsp_error_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.iport_req && (!bus.dport_req || starve_cnt_q == STARVE_LIM)) begin
                    state_d      = IBUS;
                    gnt_d_d      = 1'b0;
                    mem_addr_d   = bus.iport_addr;
                    mem_wdata_d  = '0;
                    mem_wr_d     = '0;
                    mem_valid_d  = 1'b1;
                    starve_cnt_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end else if (bus.dport_req) begin
                    state_d      = DBUS;
                    gnt_d_d      = 1'b1;
                    mem_addr_d   = bus.dport_addr;
                    mem_wdata_d  = bus.dport_wdata;
                    mem_wr_d     = bus.dport_wr;
                    mem_valid_d  = 1'b1;
                    // Only D grants that actually bypass a waiting fetch count towards starvation.
                    if (!bus.iport_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt_d   = '0;
`endif
                end
            end
            IBUS, DBUS: begin
                if (state_q == IBUS && bus.iport_kill) begin
                    kill_pend_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    rsp_rdata_d = bus.mem_rdata;
                    rsp_error_d = bus.mem_error;
                    state_d     = DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    mem_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
`endif
            end
            DONE: begin
                state_d     = IDLE;
                kill_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            kill_pend_q  <= 1'b0;
            gnt_d_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= '0;
            mem_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            kill_pend_q  <= kill_pend_d;
            gnt_d_q      <= gnt_d_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
            mem_valid_q  <= mem_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    // A flush arriving during DONE must still swallow the fetch pulse, hence the live iport_kill term.
    logic i_fire;
    logic d_fire;
    assign i_fire = (state_q == DONE) && !gnt_d_q && !kill_pend_q && !bus.iport_kill;
    assign d_fire = (state_q == DONE) && gnt_d_q;

    assign bus.iport_ready = i_fire;
    assign bus.iport_rdata = i_fire ? rsp_rdata_q : '0;
    assign bus.iport_error = i_fire & rsp_error_q;
    assign bus.dport_ready = d_fire;
    assign bus.dport_rdata = d_fire ? rsp_rdata_q : '0;
    assign bus.dport_error = d_fire & rsp_error_q;

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_valid = mem_valid_q;
endmodule

// File: tb/tb_titan_mem_arbiter.sv
// Self-checking bench for titan_mem_arbiter: vector table of single transactions plus
// directed sequences for reset, contention, flush and bus-wait limit (MEM_ARB_TIMEOUT_EN aware).
module tb_titan_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    titan_mem_arbiter_if bus ();

    titan_mem_arbiter #(
        .STARVE_MAX     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.mem_valid !== 1'b1 && n < 8);
        chk(name, {31'd0, bus.mem_valid}, 32'd1);
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wr;
        int          waits;
        logic [31:0] bus_rdata;
        logic        bus_err;
        logic [3:0]  exp_wr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v, input int idx);
        int vcnt;
        if (v.is_d) begin
            bus.dport_addr = v.addr;
            bus.dport_req  = 1'b1;
        end else begin
            bus.iport_addr = v.addr;
            bus.iport_req  = 1'b1;
        end
        bus.dport_wdata = v.wdata;
        bus.dport_wr    = v.wr;
        wait_valid("vec_valid");
        chk("vec_mem_addr", bus.mem_addr, v.addr);
        chk("vec_mem_wr", {28'd0, bus.mem_wr}, {28'd0, v.exp_wr});
        chk("vec_mem_wdata", bus.mem_wdata, v.exp_wdata);
        vcnt = 1;
        repeat (v.waits) begin
            @(negedge clk);
            if (bus.mem_valid === 1'b1) vcnt++;
        end
        chk("vec_valid_cycles", 32'(vcnt), 32'(v.waits + 1));
        bus.mem_ready = 1'b1;
        bus.mem_rdata = v.bus_rdata;
        bus.mem_error = v.bus_err;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        bus.mem_error = 1'b0;
        if (v.is_d) begin
            chk("vec_dready", {31'd0, bus.dport_ready}, 32'd1);
            chk("vec_drdata", bus.dport_rdata, v.exp_rdata);
            chk("vec_derror", {31'd0, bus.dport_error}, {31'd0, v.exp_err});
            chk("vec_iready_idle", {31'd0, bus.iport_ready}, 32'd0);
        end else begin
            chk("vec_iready", {31'd0, bus.iport_ready}, 32'd1);
            chk("vec_irdata", bus.iport_rdata, v.exp_rdata);
            chk("vec_ierror", {31'd0, bus.iport_error}, {31'd0, v.exp_err});
            chk("vec_dready_idle", {31'd0, bus.dport_ready}, 32'd0);
        end
        chk("vec_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        bus.iport_req = 1'b0;
        bus.dport_req = 1'b0;
        @(negedge clk);
        chk("vec_pulse_len", {30'd0, bus.iport_ready, bus.dport_ready}, 32'd0);
        $display("txn %0d port=%s addr=0x%08h wr=%b valid_cycles=%0d rdata=0x%08h err=%0b",
                 idx, v.is_d ? "D" : "I", v.addr, v.wr, vcnt, v.exp_rdata, v.exp_err);
    endtask

    initial begin
        byte exp_order[10];
        byte got_order[10];
        int  grants;
        int  cyc;

        vecs[0] = '{1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 4'b1111, 2, 32'h0000_0013, 1'b0,
                    4'b0000, 32'h0000_0000, 32'h0000_0013, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 0, 32'h1234_5678, 1'b0,
                    4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_3004, 32'h0000_0000, 4'b0000, 1, 32'hCAFE_F00D, 1'b1,
                    4'b0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0104, 32'hA5A5_A5A5, 4'b0101, 0, 32'h0050_0093, 1'b1,
                    4'b0000, 32'h0000_0000, 32'h0050_0093, 1'b1};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1111, 3, 32'h0000_0000, 1'b0,
                    4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // Reset held while both ports request
        rst = 1'b0;
        bus.iport_addr = 32'h0000_0040;
        bus.iport_req  = 1'b1;
        bus.iport_kill = 1'b0;
        bus.dport_addr = 32'h0000_0080;
        bus.dport_wdata = 32'h1111_2222;
        bus.dport_wr   = 4'b0000;
        bus.dport_req  = 1'b1;
        bus.mem_rdata  = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_error  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_readies", {28'd0, bus.mem_wr}, 32'd0);
        chk("rst_ports", {30'd0, bus.iport_ready, bus.dport_ready}, 32'd0);
        chk("rst_rdata", bus.iport_rdata | bus.dport_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_first_grant_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("rst_first_grant_d", bus.mem_addr, 32'h0000_0080);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("rst_first_dready", {31'd0, bus.dport_ready}, 32'd1);
        bus.iport_req = 1'b0;
        bus.dport_req = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Contention: both held, memory answers immediately
        exp_order = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
        bus.iport_addr = 32'h0000_0100;
        bus.dport_addr = 32'h0000_0200;
        bus.dport_wr   = 4'b0000;
        bus.iport_req  = 1'b1;
        bus.dport_req  = 1'b1;
        grants = 0;
        cyc = 0;
        while (grants < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("cont_one_ready", {31'd0, bus.iport_ready & bus.dport_ready}, 32'd0);
            if (bus.iport_ready) got_order[grants++] = "I";
            else if (bus.dport_ready) got_order[grants++] = "D";
            if (grants == 10) begin
                bus.iport_req = 1'b0;
                bus.dport_req = 1'b0;
            end
            bus.mem_ready = bus.mem_valid;
            bus.mem_rdata = bus.mem_addr ^ 32'h00FF_0000;
        end
        bus.mem_ready = 1'b0;
        bus.iport_req = 1'b0;
        bus.dport_req = 1'b0;
        chk("cont_grants", 32'(grants), 32'd10);
        for (int g = 0; g < 10; g++) begin
            if (g < grants) chk($sformatf("cont_order_%0d", g), 32'(got_order[g]), 32'(exp_order[g]));
        end
        $display("txn contention grants=%0d cycles=%0d", grants, cyc);
        repeat (2) @(negedge clk);

        // Flush while in IBUS, then re-fetch at a new address
        bus.iport_addr = 32'h0000_0500;
        bus.iport_req  = 1'b1;
        wait_valid("flush_valid");
        chk("flush_addr", bus.mem_addr, 32'h0000_0500);
        bus.iport_kill = 1'b1;
        @(negedge clk);
        bus.iport_kill = 1'b0;
        chk("flush_bus_kept", {31'd0, bus.mem_valid}, 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0077;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("flush_no_iready", {31'd0, bus.iport_ready}, 32'd0);
        chk("flush_no_ierror", {31'd0, bus.iport_error}, 32'd0);
        chk("flush_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        bus.iport_addr = 32'h0000_0600;
        @(negedge clk);
        chk("flush_idle_gap", {30'd0, bus.mem_valid, bus.iport_ready}, 32'd0);
        @(negedge clk);
        chk("flush_regrant_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("flush_new_addr", bus.mem_addr, 32'h0000_0600);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0099;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("refetch_iready", {31'd0, bus.iport_ready}, 32'd1);
        chk("refetch_rdata", bus.iport_rdata, 32'h0000_0099);
        bus.iport_kill = 1'b1;
        #1;
        chk("kill_in_done", {31'd0, bus.iport_ready}, 32'd0);
        bus.iport_kill = 1'b0;
        bus.iport_req  = 1'b0;
        @(negedge clk);
        $display("txn flush old=0x00000500 new=0x00000600");

        // Reset in the middle of a transaction
        bus.dport_addr = 32'h0000_0A00;
        bus.dport_req  = 1'b1;
        wait_valid("midrst_valid");
        rst = 1'b0;
        #1;
        chk("midrst_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        chk("midrst_addr", bus.mem_addr, 32'd0);
        bus.dport_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_resp", {29'd0, bus.mem_valid, bus.iport_ready, bus.dport_ready}, 32'd0);
        $display("txn reset_mid_transaction addr=0x00000A00");

        // Bus never answers
        bus.dport_addr = 32'h0000_0C00;
        bus.dport_wr   = 4'b0000;
        bus.dport_req  = 1'b1;
        wait_valid("wait_valid");
`ifdef MEM_ARB_TIMEOUT_EN
        repeat (7) @(negedge clk);
        chk("to_valid_8th", {31'd0, bus.mem_valid}, 32'd1);
        @(negedge clk);
        chk("to_valid_drop", {31'd0, bus.mem_valid}, 32'd0);
        chk("to_dready", {31'd0, bus.dport_ready}, 32'd1);
        chk("to_derror", {31'd0, bus.dport_error}, 32'd1);
        chk("to_drdata", bus.dport_rdata, 32'd0);
        bus.dport_req = 1'b0;
        @(negedge clk);
        $display("txn timeout addr=0x00000C00");
`else
        repeat (20) @(negedge clk);
        chk("nowait_valid_held", {31'd0, bus.mem_valid}, 32'd1);
        chk("nowait_no_ready", {31'd0, bus.dport_ready}, 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0055;
        bus.mem_error = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_error = 1'b0;
        chk("late_dready", {31'd0, bus.dport_ready}, 32'd1);
        chk("late_derror", {31'd0, bus.dport_error}, 32'd1);
        chk("late_drdata", bus.dport_rdata, 32'h0000_0055);
        bus.dport_req = 1'b0;
        @(negedge clk);
        $display("txn long_wait addr=0x00000C00");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
